// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fully-connected layer sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } fc_state_t;

    // Cycles between the last address issue and a stable core result.
    localparam int DRAIN_CYC = 2;
    localparam int DRAIN_W   = 2;

    function automatic int wegt_addr_w(input int cnt_bit);
        return 2 * cnt_bit;
    endfunction

    function automatic int res_w(input int data_w);
        return 4 * data_w;
    endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Node, neuron and running weight-address counters for one layer pass.
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int CNT_BIT = 10
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              feed,
    input  logic                              next_neuron,
    input  logic [CNT_BIT-1:0]                num_in,
    input  logic [CNT_BIT-1:0]                num_out,
    output logic [CNT_BIT-1:0]                node_idx,
    output logic [CNT_BIT-1:0]                neuron_idx,
    output logic [wegt_addr_w(CNT_BIT)-1:0]   wegt_addr,
    output logic                              last_node,
    output logic                              last_neuron
);

    localparam int WA = wegt_addr_w(CNT_BIT);

    assign last_node   = (node_idx == (num_in - CNT_BIT'(1)));
    assign last_neuron = (neuron_idx == (num_out - CNT_BIT'(1)));

    // Weight address is never reset between neurons, so it walks o*N+i without a multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            node_idx   <= {CNT_BIT{1'b0}};
            neuron_idx <= {CNT_BIT{1'b0}};
            wegt_addr  <= {WA{1'b0}};
        end else if (start) begin
            node_idx   <= {CNT_BIT{1'b0}};
            neuron_idx <= {CNT_BIT{1'b0}};
            wegt_addr  <= {WA{1'b0}};
        end else begin
            if (feed) begin
                node_idx  <= last_node ? {CNT_BIT{1'b0}} : node_idx + CNT_BIT'(1);
                wegt_addr <= wegt_addr + WA'(1);
            end
            if (next_neuron) begin
                neuron_idx <= neuron_idx + CNT_BIT'(1);
            end
        end
    end

endmodule

// File: rtl/fc_core_sequencer.sv
// Layer sequencer: clears the core per neuron, streams N node/weight pairs,
// captures the accumulated sum and writes it to the result buffer.
module fc_core_sequencer
    import fc_pkg::*;
#(
    parameter int IN_DATA_WITDH = 8,
    parameter int CNT_BIT       = 10,
    parameter int RELU_EN       = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_run,
    input  logic [CNT_BIT-1:0]                i_num_in,
    input  logic [CNT_BIT-1:0]                i_num_out,
    output logic                              o_idle,
    output logic                              o_done,
    output logic [CNT_BIT-1:0]                o_node_addr,
    input  logic [IN_DATA_WITDH-1:0]          i_node_data,
    output logic [wegt_addr_w(CNT_BIT)-1:0]   o_wegt_addr,
    input  logic [IN_DATA_WITDH-1:0]          i_wegt_data,
    output logic [CNT_BIT-1:0]                o_bias_addr,
    input  logic [IN_DATA_WITDH-1:0]          i_bias_data,
    output logic                              o_core_run,
    output logic                              o_core_valid,
    output logic [IN_DATA_WITDH-1:0]          o_core_node,
    output logic [IN_DATA_WITDH-1:0]          o_core_wegt,
    output logic [IN_DATA_WITDH-1:0]          o_core_bias,
    input  logic                              i_core_valid,
    input  logic [res_w(IN_DATA_WITDH)-1:0]   i_core_result,
    output logic                              o_res_valid,
    output logic [CNT_BIT-1:0]                o_res_addr,
    output logic [res_w(IN_DATA_WITDH)-1:0]   o_res_data
);

    localparam int W  = IN_DATA_WITDH;
    localparam int RW = res_w(IN_DATA_WITDH);

    fc_state_t            state_r;
    logic [CNT_BIT-1:0]   num_in_r;
    logic [CNT_BIT-1:0]   num_out_r;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic                 core_valid_r;
    logic                 first_r;

    logic                 start_s;
    logic                 feed_s;
    logic                 next_neuron_s;
    logic                 last_node_s;
    logic                 last_neuron_s;
    logic                 zero_job_s;
    logic [CNT_BIT-1:0]   node_idx_s;
    logic [CNT_BIT-1:0]   neuron_idx_s;
    logic [RW-1:0]        res_s;
    logic                 unused_s;

    assign start_s       = (state_r == ST_IDLE) && i_run;
    assign feed_s        = (state_r == ST_FEED);
    assign next_neuron_s = (state_r == ST_WRITE);
    assign zero_job_s    = (i_num_in == {CNT_BIT{1'b0}}) || (i_num_out == {CNT_BIT{1'b0}});
    assign unused_s      = i_core_valid;

    fc_addr_gen #(
        .CNT_BIT (CNT_BIT)
    ) u_addr_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start_s),
        .feed        (feed_s),
        .next_neuron (next_neuron_s),
        .num_in      (num_in_r),
        .num_out     (num_out_r),
        .node_idx    (node_idx_s),
        .neuron_idx  (neuron_idx_s),
        .wegt_addr   (o_wegt_addr),
        .last_node   (last_node_s),
        .last_neuron (last_neuron_s)
    );

    assign o_node_addr  = node_idx_s;
    assign o_bias_addr  = neuron_idx_s;
    assign o_core_valid = core_valid_r;

    // Memory data goes straight to the core; bias only rides with element 0 since the core adds it every valid cycle.
    always_comb begin
        o_core_node = core_valid_r ? i_node_data : {W{1'b0}};
        o_core_wegt = core_valid_r ? i_wegt_data : {W{1'b0}};
        o_core_bias = (core_valid_r && first_r) ? i_bias_data : {W{1'b0}};
        res_s       = ((RELU_EN != 0) && i_core_result[RW-1]) ? {RW{1'b0}} : i_core_result;
    end

    // Layer FSM with registered control and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            num_in_r     <= {CNT_BIT{1'b0}};
            num_out_r    <= {CNT_BIT{1'b0}};
            drain_cnt_r  <= {DRAIN_W{1'b0}};
            core_valid_r <= 1'b0;
            first_r      <= 1'b0;
            o_idle       <= 1'b1;
            o_done       <= 1'b0;
            o_core_run   <= 1'b0;
            o_res_valid  <= 1'b0;
            o_res_addr   <= {CNT_BIT{1'b0}};
            o_res_data   <= {RW{1'b0}};
        end else begin
            core_valid_r <= feed_s;
            first_r      <= feed_s && (node_idx_s == {CNT_BIT{1'b0}});
            o_done       <= 1'b0;
            o_core_run   <= 1'b0;
            o_res_valid  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_run) begin
                        num_in_r  <= i_num_in;
                        num_out_r <= i_num_out;
                        o_idle    <= 1'b0;
                        if (zero_job_s) begin
                            state_r <= ST_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            state_r    <= ST_CLEAR;
                            o_core_run <= 1'b1;
                        end
                    end else begin
                        o_idle <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_r <= ST_FEED;
                end
                ST_FEED: begin
                    if (last_node_s) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= {DRAIN_W{1'b0}};
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_W'(DRAIN_CYC - 1)) begin
                        state_r     <= ST_WRITE;
                        o_res_valid <= 1'b1;
                        o_res_addr  <= neuron_idx_s;
                        o_res_data  <= res_s;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (last_neuron_s) begin
                        state_r <= ST_DONE;
                        o_done  <= 1'b1;
                    end else begin
                        state_r    <= ST_CLEAR;
                        o_core_run <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    o_idle  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_core_sequencer.sv
// Randomised and directed bench for fc_core_sequencer with memory and core models.
module tb_fc_core_sequencer;

    localparam int W  = 8;
    localparam int CB = 10;
    localparam int RW = 32;
    localparam int WA = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            i_run = 1'b0;
    logic [CB-1:0]   i_num_in = '0;
    logic [CB-1:0]   i_num_out = '0;

    logic            idle0, done0, core_run, core_valid, res_valid;
    logic [CB-1:0]   node_addr, bias_addr, res_addr;
    logic [WA-1:0]   wegt_addr;
    logic [W-1:0]    core_node, core_wegt, core_bias;
    logic [RW-1:0]   res_data;

    logic            idle1, done1, core_run1, core_valid1, res_valid1;
    logic [CB-1:0]   node_addr1, bias_addr1, res_addr1;
    logic [WA-1:0]   wegt_addr1;
    logic [W-1:0]    core_node1, core_wegt1, core_bias1;
    logic [RW-1:0]   res_data1;

    logic signed [7:0] node_mem [16];
    logic signed [7:0] wegt_mem [64];
    logic signed [7:0] bias_mem [16];
    logic [7:0]        node_q, wegt_q, bias_q;
    logic signed [31:0] acc;
    logic              core_v;

    always @(posedge clk) begin
        node_q <= node_mem[node_addr[3:0]];
        wegt_q <= wegt_mem[wegt_addr[5:0]];
        bias_q <= bias_mem[bias_addr[3:0]];
    end

    // Behavioural stand-in for fully_connected_core.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= 32'sd0;
            core_v <= 1'b0;
        end else begin
            core_v <= core_valid;
            if (core_run) acc <= 32'sd0;
            else if (core_valid) acc <= acc + $signed(core_node) * $signed(core_wegt) + $signed(core_bias);
        end
    end

    fc_core_sequencer #(.IN_DATA_WITDH(W), .CNT_BIT(CB), .RELU_EN(0)) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_in(i_num_in), .i_num_out(i_num_out),
        .o_idle(idle0), .o_done(done0), .o_node_addr(node_addr), .i_node_data(node_q),
        .o_wegt_addr(wegt_addr), .i_wegt_data(wegt_q), .o_bias_addr(bias_addr), .i_bias_data(bias_q),
        .o_core_run(core_run), .o_core_valid(core_valid), .o_core_node(core_node),
        .o_core_wegt(core_wegt), .o_core_bias(core_bias), .i_core_valid(core_v),
        .i_core_result(acc), .o_res_valid(res_valid), .o_res_addr(res_addr), .o_res_data(res_data)
    );

    fc_core_sequencer #(.IN_DATA_WITDH(W), .CNT_BIT(CB), .RELU_EN(1)) dut_relu (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_in(i_num_in), .i_num_out(i_num_out),
        .o_idle(idle1), .o_done(done1), .o_node_addr(node_addr1), .i_node_data(node_q),
        .o_wegt_addr(wegt_addr1), .i_wegt_data(wegt_q), .o_bias_addr(bias_addr1), .i_bias_data(bias_q),
        .o_core_run(core_run1), .o_core_valid(core_valid1), .o_core_node(core_node1),
        .o_core_wegt(core_wegt1), .o_core_bias(core_bias1), .i_core_valid(core_v),
        .i_core_result(acc), .o_res_valid(res_valid1), .o_res_addr(res_addr1), .o_res_data(res_data1)
    );

    int n_chk = 0;
    int n_pass = 0;
    longint wr0 [8];
    longint wr1 [8];

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected layer output: bias plus dot product of the nodes with row o of the weights.
    function automatic longint ref_sum(input int n, input int o);
        longint s;
        s = longint'(bias_mem[o]);
        for (int i = 0; i < n; i++) s += longint'(node_mem[i]) * longint'(wegt_mem[(o * n + i) % 64]);
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idle"}, longint'(idle0), 1);
        check({tag, "_ctl"}, longint'({done0, core_run, core_valid, res_valid, res_addr, node_addr, bias_addr, wegt_addr}), 0);
        check({tag, "_dat"}, longint'({core_node, core_wegt, core_bias, res_data}), 0);
    endtask

    task automatic fill_rand(input int n, input int m);
        for (int i = 0; i < 16; i++) begin
            node_mem[i] = 8'($urandom);
            bias_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 64; i++) wegt_mem[i] = 8'($urandom);
    endtask

    task automatic run_job(input int n, input int m, input int abort_at, input bit noise);
        int exp_done, nwr, nval, ncrun, ndone, k, done_at;
        longint prev_node, prev_wegt, e;
        exp_done = (n == 0 || m == 0) ? 1 : m * (n + 4) + 1;
        nwr = 0; nval = 0; ncrun = 0; ndone = 0; done_at = -1;
        prev_node = 0; prev_wegt = 0;
        @(negedge clk);
        i_num_in = CB'(n); i_num_out = CB'(m); i_run = 1'b1;
        for (int c = 1; c <= exp_done + 3; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                reset_n = 1'b0;
                i_run = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                check_reset_outputs("post_abort");
                return;
            end
            if (core_run) ncrun++;
            if (done0) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c == 1) check("busy_idle", longint'(idle0), 0);
            if (c == exp_done + 1 || c == exp_done + 3) check("end_idle", longint'(idle0), 1);
            if (core_valid && n > 0) begin
                k = nval;
                check("wegt_addr", prev_wegt, longint'(k));
                check("node_addr", prev_node, longint'(k % n));
                check("bias_addr", longint'(bias_addr), longint'(k / n));
                check("core_node", longint'($signed(core_node)), longint'(node_mem[k % n]));
                check("core_wegt", longint'($signed(core_wegt)), longint'(wegt_mem[k % 64]));
                e = (k % n == 0) ? longint'(bias_mem[k / n]) : 0;
                check("core_bias", longint'($signed(core_bias)), e);
                nval++;
            end
            if (res_valid) begin
                e = ref_sum(n, nwr);
                check("wr_cycle", longint'(c), longint'((nwr + 1) * (n + 4)));
                check("wr_addr", longint'(res_addr), longint'(nwr));
                check("wr_data", longint'($signed(res_data)), e);
                check("wr_relu", longint'($signed(res_data1)), (e < 0) ? 0 : e);
                if (nwr < 8) begin
                    wr0[nwr] = longint'($signed(res_data));
                    wr1[nwr] = longint'($signed(res_data1));
                end
                nwr++;
            end
            prev_node = longint'(node_addr);
            prev_wegt = longint'(wegt_addr);
            if (noise && c <= exp_done) begin
                i_run = 1'($urandom_range(0, 1));
                i_num_in = CB'($urandom);
                i_num_out = CB'($urandom);
            end else begin
                i_run = 1'b0;
            end
        end
        check("done_cycle", longint'(done_at), longint'(exp_done));
        check("done_count", longint'(ndone), 1);
        check("n_writes", longint'(nwr), (n == 0) ? 0 : longint'(m));
        check("n_valid", longint'(nval), longint'(n * m));
        check("n_clear", longint'(ncrun), (n == 0) ? 0 : longint'(m));
    endtask

    initial begin
        fill_rand(16, 4);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        node_mem[0] = 8'sd1; node_mem[1] = 8'sd2; node_mem[2] = 8'sd3;
        wegt_mem[0] = 8'sd4; wegt_mem[1] = 8'sd5; wegt_mem[2] = 8'sd6;
        bias_mem[0] = 8'sd10;
        run_job(3, 1, 0, 1'b0);
        check("case1_val", wr0[0], 42);

        node_mem[0] = -8'sd3; node_mem[1] = 8'sd4;
        wegt_mem[0] = 8'sd5; wegt_mem[1] = 8'sd2; wegt_mem[2] = -8'sd1; wegt_mem[3] = 8'sd1;
        bias_mem[0] = 8'sd0; bias_mem[1] = 8'sd1;
        run_job(2, 2, 0, 1'b0);
        check("case2_v0", wr0[0], -7);
        check("case2_v1", wr0[1], 8);
        check("case2_relu0", wr1[0], 0);
        check("case2_relu1", wr1[1], 8);

        for (int i = 0; i < 4; i++) begin
            node_mem[i] = -8'sd128;
            wegt_mem[i] = -8'sd128;
        end
        bias_mem[0] = 8'sd127;
        run_job(4, 1, 0, 1'b0);
        check("case3_val", wr0[0], 65663);

        run_job(0, 5, 0, 1'b0);
        run_job(3, 0, 0, 1'b0);

        node_mem[0] = 8'sd1; node_mem[1] = 8'sd2; node_mem[2] = 8'sd3;
        wegt_mem[0] = 8'sd4; wegt_mem[1] = 8'sd5; wegt_mem[2] = 8'sd6;
        bias_mem[0] = 8'sd10;
        run_job(3, 2, 10, 1'b0);
        wr0[0] = 0;
        run_job(3, 1, 0, 1'b0);
        check("rerun_val", wr0[0], 42);

        fill_rand(16, 4);
        run_job(5, 3, 0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            fill_rand(16, 4);
            run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
